// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types, constants and helper functions for the buffered UART
// transmitter.
//   tx_state_e : serialiser FSM states
//   parity_e   : frame parity selection as seen on cfg_parity
//   clamp_dbits, mask_data, parity_en, parity_bit : frame-format helpers
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_MIN_DBITS = 5;
   localparam int UART_MAX_DBITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'd0,
      PAR_ODD   = 2'd1,
      PAR_EVEN  = 2'd2,
      PAR_NONE2 = 2'd3
   } parity_e;

   // Out-of-range data-bit counts collapse onto the nearest legal value.
   function automatic logic [3:0] clamp_dbits(input logic [3:0] dbits);
      logic [3:0] r;
      if (dbits < 4'(UART_MIN_DBITS)) begin
         r = 4'(UART_MIN_DBITS);
      end else if (dbits > 4'(UART_MAX_DBITS)) begin
         r = 4'(UART_MAX_DBITS);
      end else begin
         r = dbits;
      end
      return r;
   endfunction

   // Zero every bit at or above the frame's data-bit count so that parity
   // and shifting only ever see the bits that go on the line.
   function automatic logic [UART_MAX_DBITS-1:0] mask_data(
      input logic [UART_MAX_DBITS-1:0] data,
      input logic [3:0]                dbits
   );
      logic [UART_MAX_DBITS-1:0] m;
      for (int i = 0; i < UART_MAX_DBITS; i++) begin
         if (i < int'(dbits)) begin
            m[i] = data[i];
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   function automatic logic parity_en(input parity_e par);
      logic r;
      case (par)
         PAR_ODD:  r = 1'b1;
         PAR_EVEN: r = 1'b1;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

   // Data must already be masked; odd makes the total count of ones odd.
   function automatic logic parity_bit(
      input logic [UART_MAX_DBITS-1:0] data,
      input parity_e                   par
   );
      logic r;
      case (par)
         PAR_ODD:  r = ~^data;
         PAR_EVEN: r = ^data;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with valid/ready write side and pop-strobe read side.
// Read data is the current head entry (show-ahead); a pop only advances the
// read pointer. A write into an empty FIFO is not visible to the reader
// until the following cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready   write handshake (wr_ready = not full)
//   wr_data             word to store
//   rd_pop              advance head (ignored when empty)
//   rd_data             head entry
//   rd_empty            no entries stored
//   level               occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_r;
   logic [AW:0]      rptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;

   // The extra wrap bit tells full apart from empty when the indices match.
   assign full_s   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
   assign empty_s  = (wptr_r == rptr_r);
   assign push_s   = wr_valid && !full_s;
   assign pop_s    = rd_pop && !empty_s;

   assign wr_ready = !full_s;
   assign rd_empty = empty_s;
   assign rd_data  = mem_r[rptr_r[AW-1:0]];
   assign level    = wptr_r - rptr_r;

   // Pointer registers; reset flushes the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wptr_r[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// FIFO-buffered UART transmitter with runtime frame format and baud divisor.
// Frames go out LSB-first: start, 5..9 data bits, optional parity, 1 or 2
// stop bits. Consecutive queued words are sent with no idle gap.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  word handshake into the TX FIFO (ready = not full)
//   in_data         word; bits at or above cfg_dbits are ignored
//   cfg_div         clocks per bit (0 behaves as 1)
//   cfg_dbits       data bits, clamped to 5..9
//   cfg_parity      0 none, 1 odd, 2 even, 3 none
//   cfg_stop2       0: one stop bit, 1: two stop bits
//   tx              serial line, idle high, registered
//   busy            frame in progress or FIFO non-empty
//   fifo_level      FIFO occupancy
// cfg_* are sampled only when a word is popped and hold for that frame.
// ---------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int MAX_DBITS  = UART_MAX_DBITS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAX_DBITS-1:0]          in_data,
   input  logic [DIV_W-1:0]              cfg_div,
   input  logic [3:0]                    cfg_dbits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   tx_state_e              state_r,   state_s;
   logic [DIV_W-1:0]       div_cnt_r, div_cnt_s;
   logic [DIV_W-1:0]       div_l_r,   div_l_s;
   logic [3:0]             dbits_l_r, dbits_l_s;
   logic [3:0]             bit_idx_r, bit_idx_s;
   parity_e                par_l_r,   par_l_s;
   logic                   stop2_l_r, stop2_l_s;
   logic                   stop_idx_r, stop_idx_s;
   logic [MAX_DBITS-1:0]   shift_r,   shift_s;
   logic                   tx_r,      tx_s;

   logic                   pop_s;
   logic                   load_s;
   logic                   bit_end_s;
   logic                   fifo_empty_s;
   logic [MAX_DBITS-1:0]   fifo_data_s;
   logic [3:0]             dbits_cfg_s;

   uart_sync_fifo #(
      .WIDTH (MAX_DBITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (in_valid),
      .wr_ready (in_ready),
      .wr_data  (in_data),
      .rd_pop   (pop_s),
      .rd_data  (fifo_data_s),
      .rd_empty (fifo_empty_s),
      .level    (fifo_level)
   );

   // Last clock of the current bit; div_l_r is never zero so no underflow.
   assign bit_end_s   = (div_cnt_r == (div_l_r - DIV_ONE));
   assign dbits_cfg_s = clamp_dbits(cfg_dbits);

   // Next-state, next-tx and config-latch logic for the serialiser.
   always_comb begin
      state_s    = state_r;
      div_cnt_s  = div_cnt_r;
      div_l_s    = div_l_r;
      dbits_l_s  = dbits_l_r;
      bit_idx_s  = bit_idx_r;
      par_l_s    = par_l_r;
      stop2_l_s  = stop2_l_r;
      stop_idx_s = stop_idx_r;
      shift_s    = shift_r;
      tx_s       = tx_r;
      pop_s      = 1'b0;
      load_s     = 1'b0;

      case (state_r)
         ST_IDLE: begin
            tx_s      = 1'b1;
            div_cnt_s = '0;
            if (!fifo_empty_s) begin
               load_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_START: begin
            if (bit_end_s) begin
               state_s   = ST_DATA;
               div_cnt_s = '0;
               bit_idx_s = 4'd0;
               tx_s      = shift_r[0];
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end

         ST_DATA: begin
            if (bit_end_s) begin
               div_cnt_s = '0;
               if (bit_idx_r == (dbits_l_r - 4'd1)) begin
                  if (parity_en(par_l_r)) begin
                     state_s = ST_PARITY;
                     tx_s    = parity_bit(shift_r, par_l_r);
                  end else begin
                     state_s    = ST_STOP;
                     stop_idx_s = 1'b0;
                     tx_s       = 1'b1;
                  end
               end else begin
                  bit_idx_s = bit_idx_r + 4'd1;
                  tx_s      = shift_r[bit_idx_s];
               end
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end

         ST_PARITY: begin
            if (bit_end_s) begin
               state_s    = ST_STOP;
               div_cnt_s  = '0;
               stop_idx_s = 1'b0;
               tx_s       = 1'b1;
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end

         ST_STOP: begin
            if (bit_end_s) begin
               div_cnt_s = '0;
               if (stop2_l_r && !stop_idx_r) begin
                  stop_idx_s = 1'b1;
                  tx_s       = 1'b1;
               end else if (!fifo_empty_s) begin
                  // Chain straight into the next frame: no idle bit.
                  load_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
                  tx_s    = 1'b1;
               end
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end

         default: begin
            state_s   = ST_IDLE;
            div_cnt_s = '0;
            tx_s      = 1'b1;
         end
      endcase

      // Popping a word snapshots the whole frame format for that frame.
      if (load_s) begin
         pop_s      = 1'b1;
         state_s    = ST_START;
         div_cnt_s  = '0;
         bit_idx_s  = 4'd0;
         stop_idx_s = 1'b0;
         tx_s       = 1'b0;
         div_l_s    = (cfg_div == '0) ? DIV_ONE : cfg_div;
         dbits_l_s  = dbits_cfg_s;
         par_l_s    = parity_e'(cfg_parity);
         stop2_l_s  = cfg_stop2;
         shift_s    = mask_data(fifo_data_s, dbits_cfg_s);
      end else begin
         pop_s = 1'b0;
      end
   end

   // Serialiser state, counters, latched frame format and registered tx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         div_cnt_r  <= '0;
         div_l_r    <= DIV_ONE;
         dbits_l_r  <= 4'(UART_MIN_DBITS);
         bit_idx_r  <= 4'd0;
         par_l_r    <= PAR_NONE;
         stop2_l_r  <= 1'b0;
         stop_idx_r <= 1'b0;
         shift_r    <= '0;
         tx_r       <= 1'b1;
      end else begin
         state_r    <= state_s;
         div_cnt_r  <= div_cnt_s;
         div_l_r    <= div_l_s;
         dbits_l_r  <= dbits_l_s;
         bit_idx_r  <= bit_idx_s;
         par_l_r    <= par_l_s;
         stop2_l_r  <= stop2_l_s;
         stop_idx_r <= stop_idx_s;
         shift_r    <= shift_s;
         tx_r       <= tx_s;
      end
   end

   assign tx   = tx_r;
   assign busy = (state_r != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Scoreboard bench: each accepted word queues its expected frame format;
// a line monitor reconstructs every frame from tx and checks it bit by bit
// against a frame built arithmetically from the word and its format.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

   typedef struct {
      logic [8:0] data;
      int         dbits;
      int         par;
      bit         stop2;
      int         div;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  in_data;
   logic [15:0] cfg_div;
   logic [3:0]  cfg_dbits;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        tx;
   logic        busy;
   logic [4:0]  fifo_level;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   frames_started = 0;
   bit   abort = 1'b0;
   exp_t sb[$];
   int   starts[$];

   uart_tx_buffered dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .cfg_div    (cfg_div),
      .cfg_dbits  (cfg_dbits),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic set_cfg(input int div, input int dbits, input int par, input bit stop2);
      @(negedge clk);
      cfg_div    = 16'(div);
      cfg_dbits  = 4'(dbits);
      cfg_parity = 2'(par);
      cfg_stop2  = stop2;
   endtask

   // Offer one word and hold it until accepted; the expectation uses the
   // format currently on cfg_*, which the bench keeps stable until popped.
   task automatic push(input logic [8:0] w);
      exp_t e;
      int   t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      t = 0;
      while (!in_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("push_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      e.data  = w;
      e.dbits = int'(cfg_dbits);
      e.par   = int'(cfg_parity);
      e.stop2 = cfg_stop2;
      e.div   = int'(cfg_div);
      sb.push_back(e);
   endtask

   task automatic wait_started(input int n, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (frames_started >= n) break;
         @(negedge clk);
      end
      chk("frame_start", int'(frames_started >= n), 1);
   endtask

   task automatic wait_idle(input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) break;
      end
      chk("drain_busy", int'(busy), 0);
      chk("drain_queue", sb.size(), 0);
   endtask

   // Line monitor and reference model.
   initial begin
      exp_t e;
      int   mb[16];
      int   nb, nd, d, ones, b;
      bit   ok;
      forever begin
         @(negedge clk);
         if (!abort && tx === 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_start", 1, 0);
               while (!abort && tx === 1'b0) @(negedge clk);
            end else begin
               e = sb.pop_front();
               starts.push_back(cyc);
               frames_started++;
               nd = (e.dbits < 5) ? 5 : ((e.dbits > 9) ? 9 : e.dbits);
               d  = (e.div == 0) ? 1 : e.div;
               nb = 0;
               mb[nb++] = 0;
               ones = 0;
               for (int i = 0; i < nd; i++) begin
                  b = (int'(e.data) >> i) % 2;
                  ones += b;
                  mb[nb++] = b;
               end
               if (e.par == 1) mb[nb++] = (ones % 2 == 0) ? 1 : 0;
               if (e.par == 2) mb[nb++] = (ones % 2 == 1) ? 1 : 0;
               mb[nb++] = 1;
               if (e.stop2) mb[nb++] = 1;
               ok = 1'b1;
               for (int j = 0; j < nb * d; j++) begin
                  if (j > 0) @(negedge clk);
                  if (abort) break;
                  if (tx !== mb[j / d][0]) ok = 1'b0;
                  if ((j % d) == d - 1) begin
                     chk($sformatf("frame_bit%0d", j / d),
                         ok ? mb[j / d] : 1 - mb[j / d], mb[j / d]);
                     ok = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      int base;
      int s;
      int t;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 9'd0;
      cfg_div    = 16'd4;
      cfg_dbits  = 4'd8;
      cfg_parity = 2'd0;
      cfg_stop2  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_level", int'(fifo_level), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1, div 4: latency, bit pattern and frame length.
      set_cfg(4, 8, 0, 1'b0);
      base = starts.size();
      push(9'h0A5);
      @(negedge clk);
      chk("lat_e0_tx", int'(tx), 1);
      chk("lat_e0_busy", int'(busy), 1);
      @(negedge clk);
      chk("lat_e1_tx", int'(tx), 0);
      t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (starts.size() > base) chk("frame_len_8n1", cyc - starts[base], 40);
      else chk("frame_seen", starts.size(), base + 1);
      wait_idle(100);

      // 7 bits, odd then even parity; format switched mid-frame.
      set_cfg(3, 7, 1, 1'b0);
      push(9'h055);
      wait_started(frames_started + 1, 100);
      set_cfg(3, 7, 2, 1'b0);
      push(9'h055);
      wait_idle(200);

      // 8N2, div 2, back-to-back frames without idle gap.
      set_cfg(2, 8, 0, 1'b1);
      base = starts.size();
      push(9'h000);
      push(9'h0FF);
      wait_idle(200);
      if (starts.size() > base + 1) chk("b2b_gap", starts[base + 1] - starts[base], 22);
      else chk("b2b_count", starts.size(), base + 2);

      // div 100: fill the FIFO, hold a word while full, then see space reopen.
      set_cfg(100, 8, 0, 1'b0);
      base = starts.size();
      for (int i = 0; i < 17; i++) push(9'($urandom_range(0, 511)));
      @(negedge clk);
      chk("full_level", int'(fifo_level), 16);
      chk("full_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      in_data  = 9'h1AA;
      repeat (5) @(negedge clk);
      chk("full_no_push", int'(fifo_level), 16);
      in_valid = 1'b0;
      t = 0;
      while (fifo_level == 5'd16 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("pop_ready", int'(in_ready), 1);
      chk("pop_level", int'(fifo_level), 15);
      wait_idle(20000);
      if (starts.size() > base + 16) chk("stream_len", starts[base + 16] - starts[base], 16000);
      else chk("stream_count", starts.size(), base + 17);

      // dbits 8 -> 5 while the first frame is on the line.
      set_cfg(2, 8, 0, 1'b0);
      push(9'h0FF);
      wait_started(frames_started + 1, 100);
      repeat (3) @(negedge clk);
      set_cfg(2, 5, 0, 1'b0);
      push(9'h0FF);
      wait_idle(200);

      // Randomised formats, including out-of-range dbits and div 0.
      for (int bt = 0; bt < 8; bt++) begin
         set_cfg($urandom_range(0, 5), $urandom_range(3, 12), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
         for (int i = 0; i < 6; i++) push(9'($urandom_range(0, 511)));
         wait_idle(3000);
      end

      // Asynchronous reset in the middle of a data bit.
      set_cfg(4, 8, 0, 1'b0);
      push(9'h0FF);
      wait_started(frames_started + 1, 100);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tx", int'(tx), 1);
      chk("arst_busy", int'(busy), 0);
      chk("arst_level", int'(fifo_level), 0);
      chk("arst_ready", int'(in_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      abort = 1'b0;
      s = frames_started;
      repeat (200) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_tx", int'(tx), 1);
      chk("post_rst_frames", frames_started, s);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      chk("watchdog", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
